// File: rtl/fifo_wr_arb.sv
// Two-producer round-robin write arbiter feeding a single FIFO write port.
// A grant lasts up to MAX_BURST words and hands off directly to a waiting producer.
module fifo_wr_arb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     nxt;
    state_t     other;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic       last;
    logic       xfer;
    logic       cur_valid;
    logic       oth_valid;

    // Readies are held low while reset is asserted so an in-flight grant never writes.
    always_comb begin
        req0_ready = (state == GNT0) & ~fifo_full & ~rstn;
        req1_ready = (state == GNT1) & ~fifo_full & ~rstn;
        xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        fifo_wr_en = xfer;
        fifo_din   = '0;
        case (state)
            GNT0:    fifo_din = req0_data;
            GNT1:    fifo_din = req1_data;
            default: fifo_din = '0;
        endcase
    end

    always_comb begin
        cur_valid = (state == GNT1) ? req1_valid : req0_valid;
        oth_valid = (state == GNT1) ? req0_valid : req1_valid;
        other     = (state == GNT1) ? GNT0 : GNT1;
        nxt       = state;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (req0_valid && (!req1_valid || last))
                    nxt = GNT0;
                else if (req1_valid)
                    nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!cur_valid || (xfer && cnt == LAST_CNT)) begin
                    nxt_cnt = '0;
                    if (oth_valid)
                        nxt = other;
                    else if (cur_valid)
                        nxt = state;
                    else
                        nxt = IDLE;
                end else if (xfer) begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            default: begin
                nxt     = IDLE;
                nxt_cnt = '0;
            end
        endcase
    end

    // grant/busy are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt_cnt;
            if (nxt != IDLE)
                last <= (nxt == GNT1);
            grant <= {nxt == GNT1, nxt == GNT0};
            busy  <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomised self-checking bench for the fifo_wr_arb write arbiter.
module tb_fifo_wr_arb;

    logic       clk;
    logic       rstn;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_din;
    logic [1:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bit         f_pat  [16];
    logic [1:0] e_grant[16];
    bit         e_wr   [16];
    logic [7:0] e_din  [16];

    fifo_wr_arb #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant      (grant),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn       = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        fifo_full  = 1'b0;
        cyc();
    endtask

    // Producers advance to their next word whenever their word was accepted.
    task automatic run_vec(input string tag, input int n);
        logic h0, h1;
        for (int k = 0; k < n; k++) begin
            fifo_full = f_pat[k];
            #1;
            chk({tag, "_grant"}, grant, e_grant[k]);
            chk({tag, "_wr"}, fifo_wr_en, e_wr[k]);
            chk({tag, "_din"}, fifo_din, e_din[k]);
            h0 = req0_valid & req0_ready;
            h1 = req1_valid & req1_ready;
            cyc();
            if (h0) req0_data = req0_data + 8'd1;
            if (h1) req1_data = req1_data + 8'd1;
        end
    endtask

    initial begin
        int unsigned s0, s1, e0, e1, run;
        logic [1:0]  prev_grant;
        logic        h0, h1;

        // reset state
        do_reset();
        cyc();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy0", req0_ready, 1'b0);
        chk("rst_rdy1", req1_ready, 1'b0);
        chk("rst_wr", fifo_wr_en, 1'b0);

        // single producer, three words, then back to idle
        cyc();
        rstn = 1'b0; req0_valid = 1'b1; req0_data = 8'h11;
        #1;
        chk("t1_idle", grant, 2'b00);
        cyc();
        #1;
        chk("t1_g", grant, 2'b01);
        chk("t1_w0", fifo_wr_en, 1'b1);
        chk("t1_d0", fifo_din, 8'h11);
        cyc();
        req0_data = 8'h12;
        #1;
        chk("t1_d1", fifo_din, 8'h12);
        chk("t1_w1", fifo_wr_en, 1'b1);
        cyc();
        req0_data = 8'h13;
        #1;
        chk("t1_d2", fifo_din, 8'h13);
        chk("t1_w2", fifo_wr_en, 1'b1);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("t1_w3", fifo_wr_en, 1'b0);
        cyc();
        #1;
        chk("t1_end_g", grant, 2'b00);
        chk("t1_end_b", busy, 1'b0);

        // both valid: bursts of four alternate with no bubble
        do_reset();
        rstn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'hA0; req1_data = 8'hB0;
        #1;
        chk("t2_idle", grant, 2'b00);
        cyc();
        for (int k = 0; k < 12; k++) begin
            f_pat[k] = 1'b0;
            e_wr[k]  = 1'b1;
            if (k < 4) begin
                e_grant[k] = 2'b01; e_din[k] = 8'(8'hA0 + k);
            end else if (k < 8) begin
                e_grant[k] = 2'b10; e_din[k] = 8'(8'hB0 + k - 4);
            end else begin
                e_grant[k] = 2'b01; e_din[k] = 8'(8'hA0 + k - 4);
            end
        end
        run_vec("t2", 12);

        // full stall in the middle of a burst
        do_reset();
        rstn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'hA0; req1_data = 8'hB0;
        cyc();
        for (int k = 0; k < 10; k++) begin
            f_pat[k]   = (k >= 2 && k <= 6);
            e_wr[k]    = !(k >= 2 && k <= 6);
            e_grant[k] = (k == 9) ? 2'b10 : 2'b01;
            e_din[k]   = (k < 2) ? 8'(8'hA0 + k) : (k < 8) ? 8'hA2 : (k == 8) ? 8'hA3 : 8'hB0;
        end
        run_vec("t3", 10);

        // reset while producer 1 is mid-burst
        do_reset();
        rstn = 1'b0; req1_valid = 1'b1; req1_data = 8'hC0;
        cyc();
        #1;
        chk("t4_g", grant, 2'b10);
        chk("t4_d0", fifo_din, 8'hC0);
        cyc();
        req1_data = 8'hC1;
        #1;
        chk("t4_d1", fifo_din, 8'hC1);
        cyc();
        req1_data = 8'hC2; rstn = 1'b1;
        #1;
        chk("t4_rst_wr", fifo_wr_en, 1'b0);
        chk("t4_rst_rdy", req1_ready, 1'b0);
        cyc();
        rstn = 1'b0; req0_valid = 1'b1; req0_data = 8'h50;
        #1;
        chk("t4_post_g", grant, 2'b00);
        chk("t4_post_b", busy, 1'b0);
        chk("t4_post_wr", fifo_wr_en, 1'b0);
        cyc();
        #1;
        chk("t4_first_g", grant, 2'b01);
        chk("t4_first_d", fifo_din, 8'h50);
        chk("t4_first_wr", fifo_wr_en, 1'b1);

        // producer 0 goes idle after one word; hand-off to producer 1 without a bubble
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("t5_drop_wr", fifo_wr_en, 1'b0);
        chk("t5_drop_g", grant, 2'b01);
        cyc();
        req1_data = 8'hA5;
        #1;
        chk("t5_g", grant, 2'b10);
        chk("t5_b", busy, 1'b1);
        chk("t5_d", fifo_din, 8'hA5);
        chk("t5_wr", fifo_wr_en, 1'b1);
        req1_valid = 1'b0;
        cyc();

        // random valid/full traffic against a per-producer scoreboard
        do_reset();
        rstn = 1'b0;
        s0 = 0; s1 = 0; e0 = 0; e1 = 0; run = 0;
        prev_grant = 2'b00;
        req0_data = 8'h00; req1_data = 8'h80;
        for (int c = 0; c < 10000; c++) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            chk("r_nowrfull", fifo_wr_en & fifo_full, 1'b0);
            chk("r_onerdy", req0_ready & req1_ready, 1'b0);
            chk("r_busy", busy, |grant);
            if (grant != prev_grant) run = 0;
            if (fifo_wr_en) begin
                if (fifo_din[7] == 1'b0) begin
                    chk("r_din0", fifo_din, {1'b0, e0[6:0]});
                    chk("r_hs0", req0_valid & req0_ready, 1'b1);
                    e0++;
                end else begin
                    chk("r_din1", fifo_din, {1'b1, e1[6:0]});
                    chk("r_hs1", req1_valid & req1_ready, 1'b1);
                    e1++;
                end
                run++;
                chk("r_burst", run <= 4, 1'b1);
            end
            if (grant == 2'b00 || (grant == 2'b01 && !req1_valid) || (grant == 2'b10 && !req0_valid))
                run = 0;
            prev_grant = grant;
            h0 = req0_valid & req0_ready;
            h1 = req1_valid & req1_ready;
            cyc();
            if (h0) s0++;
            if (h1) s1++;
            if (h0 || !req0_valid) req0_valid = 1'($urandom_range(0, 1));
            if (h1 || !req1_valid) req1_valid = 1'($urandom_range(0, 1));
            req0_data = {1'b0, s0[6:0]};
            req1_data = {1'b1, s1[6:0]};
        end
        chk("r_progress", (e0 > 100) && (e1 > 100), 1'b1);
        chk("r_count0", e0, s0);
        chk("r_count1", e1, s1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
